// File: rtl/muldiv_ctrl.sv
// ============================================================================
//  Module   : muldiv_ctrl
//  Purpose  : Multi-cycle HI/LO multiply/divide unit with mthi/mtlo writes.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module muldiv_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        IntReg,
    output logic        start,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [3:0] c_OP_MULT  = 4'd1;
    localparam logic [3:0] c_OP_MULTU = 4'd2;
    localparam logic [3:0] c_OP_DIV   = 4'd3;
    localparam logic [3:0] c_OP_DIVU  = 4'd4;
    localparam logic [3:0] c_OP_MTHI  = 4'd5;
    localparam logic [3:0] c_OP_MTLO  = 4'd6;

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [31:0]        r_a;
    logic [31:0]        r_b;
    logic               r_is_div;
    logic               r_signed;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;

    logic               w_start;
    logic               w_commit;
    logic               w_mthi;
    logic               w_mtlo;
    logic               w_is_div_nxt;
    logic               w_signed_nxt;

    // ------------------------------------------------------------------
    // Next-state / control decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_start      = 1'b0;
        w_commit     = 1'b0;
        w_mthi       = 1'b0;
        w_mtlo       = 1'b0;
        w_is_div_nxt = r_is_div;
        w_signed_nxt = r_signed;
        case (r_state)
            S_IDLE: begin
                if (!IntReg) begin
                    case (op)
                        c_OP_MULT, c_OP_MULTU: begin
                            w_start      = 1'b1;
                            w_state_nxt  = S_BUSY;
                            w_cnt_nxt    = CNT_W'(MULT_CYCLES);
                            w_is_div_nxt = 1'b0;
                            w_signed_nxt = (op == c_OP_MULT);
                        end
                        c_OP_DIV, c_OP_DIVU: begin
                            w_start      = 1'b1;
                            w_state_nxt  = S_BUSY;
                            w_cnt_nxt    = CNT_W'(DIV_CYCLES);
                            w_is_div_nxt = 1'b1;
                            w_signed_nxt = (op == c_OP_DIV);
                        end
                        c_OP_MTHI: w_mthi = 1'b1;
                        c_OP_MTLO: w_mtlo = 1'b1;
                        default: ;
                    endcase
                end
            end
            S_BUSY: begin
                w_cnt_nxt = r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) begin
                    w_commit    = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Arithmetic on the latched operands
    // ------------------------------------------------------------------
    logic signed [63:0] w_prod_s;
    logic        [63:0] w_prod_u;
    logic               w_neg_a;
    logic               w_neg_b;
    logic        [31:0] w_ua;
    logic        [31:0] w_ub;
    logic        [31:0] w_ub_safe;
    logic        [31:0] w_uq;
    logic        [31:0] w_ur;
    logic        [31:0] w_q;
    logic        [31:0] w_r;

    assign w_prod_s  = $signed({{32{r_a[31]}}, r_a}) * $signed({{32{r_b[31]}}, r_b});
    assign w_prod_u  = {32'd0, r_a} * {32'd0, r_b};

    // Signed divide via magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
    assign w_neg_a   = r_signed & r_a[31];
    assign w_neg_b   = r_signed & r_b[31];
    assign w_ua      = w_neg_a ? (32'd0 - r_a) : r_a;
    assign w_ub      = w_neg_b ? (32'd0 - r_b) : r_b;
    assign w_ub_safe = (w_ub == 32'd0) ? 32'd1 : w_ub;
    assign w_uq      = w_ua / w_ub_safe;
    assign w_ur      = w_ua % w_ub_safe;
    assign w_q       = (w_neg_a ^ w_neg_b) ? (32'd0 - w_uq) : w_uq;
    assign w_r       = w_neg_a ? (32'd0 - w_ur) : w_ur;

    // ------------------------------------------------------------------
    // State, operand latch and HI/LO registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_a      <= 32'd0;
            r_b      <= 32'd0;
            r_is_div <= 1'b0;
            r_signed <= 1'b0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_is_div <= w_is_div_nxt;
            r_signed <= w_signed_nxt;
            if (w_start) begin
                r_a <= A;
                r_b <= B;
            end
            if (w_commit) begin
                if (r_is_div) begin
                    // Divide by zero leaves HI/LO untouched
                    if (r_b != 32'd0) begin
                        r_hi <= w_r;
                        r_lo <= w_q;
                    end
                end else if (r_signed) begin
                    r_hi <= w_prod_s[63:32];
                    r_lo <= w_prod_s[31:0];
                end else begin
                    r_hi <= w_prod_u[63:32];
                    r_lo <= w_prod_u[31:0];
                end
            end
            if (w_mthi) r_hi <= A;
            if (w_mtlo) r_lo <= A;
        end
    end

    assign start = w_start;
    assign busy  = (r_state == S_BUSY);
    assign HI    = r_hi;
    assign LO    = r_lo;

endmodule

`default_nettype wire
